xor_serial_arbiter: RTL and testbench

- Shares one gate-level Xor instance between two requesters.
- Each requester submits a pair of WIDTH-bit operands. The block grants requesters round-robin and serialises the operands LSB-first through the single Xor gate, one bit per clock.
- It returns the WIDTH-bit bitwise XOR word plus its parity (XOR-reduction) on a valid/ready response port.
- Sits beside the Hack chip gate library as a time-multiplexed, area-minimal XOR/parity resource.

---
 rtl/xor_serial_arbiter_pkg.sv | 27 ++
 rtl/xor_serial_arbiter_xor.sv | 18 +
 rtl/xor_serial_arbiter.sv | 141 ++++++++++++++
 tb/tb_xor_serial_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_serial_arbiter_pkg.sv
// Shared definitions for the time-multiplexed XOR/parity arbiter: FSM encoding,
// default operand width and the round-robin grant rule.
package xor_serial_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ArbState;

    // Under contention the requester that was not served last wins; otherwise
    // whichever one is valid is granted (0 when neither is, which callers ignore).
    function automatic logic pickGrant(input logic valid0,
                                       input logic valid1,
                                       input logic lastGrant);
        logic grant;
        if (valid0 && valid1) begin
            grant = ~lastGrant;
        end else begin
            grant = valid1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/xor_serial_arbiter_xor.sv
// Hack-library style gate-level Xor built from four NAND stages; this is the
// single-bit resource the arbiter time-shares.
module Xor (
    input  logic i_a,
    input  logic i_b,
    output logic o_out
);

    logic w_nandAb;
    logic w_nandA;
    logic w_nandB;

    assign w_nandAb = ~(i_a & i_b);
    assign w_nandA  = ~(i_a & w_nandAb);
    assign w_nandB  = ~(i_b & w_nandAb);
    assign o_out    = ~(w_nandA & w_nandB);

endmodule

// File: rtl/xor_serial_arbiter.sv
// Two-requester round-robin arbiter that streams operand pairs LSB-first through
// one shared bit Xor and returns the XOR word plus its parity on a valid/ready port.
module xor_serial_arbiter
    import xor_serial_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_parity,
    input  logic             resp_ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    ArbState          r_state;
    ArbState          w_nextState;
    logic             r_lastGrant;
    logic             r_respId;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_result;
    logic             r_parity;
    logic [CW-1:0]    r_count;

    logic             w_anyValid;
    logic             w_grant;
    logic             w_bit;
    logic             w_parityNext;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_resultNext;

    assign w_anyValid = req0_valid | req1_valid;
    assign w_grant    = pickGrant(req0_valid, req1_valid, r_lastGrant);
    assign w_lastBit  = (r_count == CW'(WIDTH - 1));

    // The one shared datapath XOR: operand bits enter LSB-first.
    Xor BitXor (
        .i_a  (r_aSh[0]),
        .i_b  (r_bSh[0]),
        .o_out(w_bit)
    );

    Xor ParityXor (
        .i_a  (r_parity),
        .i_b  (w_bit),
        .o_out(w_parityNext)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit i sits at position i;
    // written as shift/or so it stays legal when WIDTH is 1.
    assign w_resultNext = (r_result >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_nextState = SHIFT;
            SHIFT:   if (w_lastBit)  w_nextState = DONE;
            DONE:    if (resp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Ready is only offered while idle, so a held response blocks both requesters.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        if (!reset) begin
            if (r_state == IDLE && w_anyValid) begin
                req0_ready = ~w_grant;
                req1_ready = w_grant;
            end
            resp_valid = (r_state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= 1'b1;
            r_respId    <= 1'b0;
            r_aSh       <= '0;
            r_bSh       <= '0;
            r_result    <= '0;
            r_parity    <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_aSh    <= w_grant ? req1_a : req0_a;
                        r_bSh    <= w_grant ? req1_b : req0_b;
                        r_respId <= w_grant;
                        r_result <= '0;
                        r_parity <= 1'b0;
                        r_count  <= '0;
                    end
                end
                SHIFT: begin
                    r_result <= w_resultNext;
                    r_parity <= w_parityNext;
                    r_aSh    <= r_aSh >> 1;
                    r_bSh    <= r_bSh >> 1;
                    r_count  <= r_count + CW'(1);
                end
                DONE: begin
                    if (resp_ready) begin
                        r_lastGrant <= r_respId;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign resp_id     = r_respId;
    assign resp_out    = r_result;
    assign resp_parity = r_parity;

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed bench for xor_serial_arbiter: hand-computed vectors for a 16-bit
// instance plus a WIDTH=1 instance for the single-shift boundary.
module tb_xor_serial_arbiter;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0Valid;
    logic [WIDTH-1:0] req0A;
    logic [WIDTH-1:0] req0B;
    logic             req0Ready;
    logic             req1Valid;
    logic [WIDTH-1:0] req1A;
    logic [WIDTH-1:0] req1B;
    logic             req1Ready;
    logic             respValid;
    logic             respId;
    logic [WIDTH-1:0] respOut;
    logic             respParity;
    logic             respReady;

    logic             w1Req0Valid;
    logic [0:0]       w1Req0A;
    logic [0:0]       w1Req0B;
    logic             w1Req0Ready;
    logic             w1Req1Ready;
    logic             w1RespValid;
    logic             w1RespId;
    logic [0:0]       w1RespOut;
    logic             w1RespParity;
    logic [0:0]       w1Zero;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    xor_serial_arbiter #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0Valid),
        .req0_a     (req0A),
        .req0_b     (req0B),
        .req0_ready (req0Ready),
        .req1_valid (req1Valid),
        .req1_a     (req1A),
        .req1_b     (req1B),
        .req1_ready (req1Ready),
        .resp_valid (respValid),
        .resp_id    (respId),
        .resp_out   (respOut),
        .resp_parity(respParity),
        .resp_ready (respReady)
    );

    xor_serial_arbiter #(.WIDTH(1)) u_dutW1 (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (w1Req0Valid),
        .req0_a     (w1Req0A),
        .req0_b     (w1Req0B),
        .req0_ready (w1Req0Ready),
        .req1_valid (1'b0),
        .req1_a     (w1Zero),
        .req1_b     (w1Zero),
        .req1_ready (w1Req1Ready),
        .resp_valid (w1RespValid),
        .resp_id    (w1RespId),
        .resp_out   (w1RespOut),
        .resp_parity(w1RespParity),
        .resp_ready (1'b1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0,
                                 input logic [WIDTH-1:0] b0, input logic v1,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
        req0Valid = v0;
        req0A     = a0;
        req0B     = b0;
        req1Valid = v1;
        req1A     = a1;
        req1B     = b1;
        #1;
    endtask

    task automatic applyReset;
        reset = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst resp_valid", respValid, 0);
        checkOutput("rst resp_out", respOut, 0);
        checkOutput("rst ready0", req0Ready, 0);
        checkOutput("rst ready1", req1Ready, 0);
        reset = 1'b0;
        #1;
    endtask

    // Called in the accept cycle: steps past it, withdraws the served request and
    // waits (bounded) for the response; lat is -1 if none arrives.
    task automatic acceptAndWait(input int who, output int lat);
        stepCycle();
        lat = 1;
        if (who == 0) req0Valid = 1'b0;
        else          req1Valid = 1'b0;
        while (!respValid && lat < 40) begin
            stepCycle();
            lat++;
        end
        if (!respValid) lat = -1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int lat;
        int lastAccept;
        int acceptCount;
        int respCount;

        reset       = 1'b1;
        respReady   = 1'b1;
        w1Req0Valid = 1'b0;
        w1Req0A     = 1'b0;
        w1Req0B     = 1'b0;
        w1Zero      = 1'b0;
        applyStimulus(0, '0, '0, 0, '0, '0);

        // Basic transfer
        applyReset();
        checkOutput("idle ready0", req0Ready, 0);
        applyStimulus(1, 16'hF0F0, 16'h0FF0, 0, '0, '0);
        checkOutput("t1 ready0", req0Ready, 1);
        checkOutput("t1 ready1", req1Ready, 0);
        acceptAndWait(0, lat);
        checkOutput("t1 latency", lat, 17);
        checkOutput("t1 out", respOut, 16'hFF00);
        checkOutput("t1 parity", respParity, 0);
        checkOutput("t1 id", respId, 0);
        stepCycle();
        checkOutput("t1 pulse", respValid, 0);

        // Simultaneous requests after reset: requester 0 first
        applyReset();
        applyStimulus(1, 16'hFFFF, 16'h0000, 1, 16'h0001, 16'h0000);
        checkOutput("t2 ready0", req0Ready, 1);
        checkOutput("t2 ready1 blocked", req1Ready, 0);
        acceptAndWait(0, lat);
        checkOutput("t2 latency0", lat, 17);
        checkOutput("t2 out0", respOut, 16'hFFFF);
        checkOutput("t2 parity0", respParity, 0);
        checkOutput("t2 id0", respId, 0);
        stepCycle();
        checkOutput("t2 ready1 at +18", req1Ready, 1);
        acceptAndWait(1, lat);
        checkOutput("t2 latency1", lat, 17);
        checkOutput("t2 out1", respOut, 16'h0001);
        checkOutput("t2 parity1", respParity, 1);
        checkOutput("t2 id1", respId, 1);
        stepCycle();

        // Back-pressure in DONE with requester 1 waiting
        respReady = 1'b0;
        applyStimulus(1, 16'h1234, 16'h00FF, 0, '0, '0);
        checkOutput("t3 ready0", req0Ready, 1);
        acceptAndWait(0, lat);
        checkOutput("t3 latency", lat, 17);
        applyStimulus(0, '0, '0, 1, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3 hold valid", respValid, 1);
            checkOutput("t3 hold out", respOut, 16'h12CB);
            checkOutput("t3 hold parity", respParity, 1);
            checkOutput("t3 hold ready0", req0Ready, 0);
            checkOutput("t3 hold ready1", req1Ready, 0);
            stepCycle();
        end
        respReady = 1'b1;
        #1;
        checkOutput("t3 valid at release", respValid, 1);
        stepCycle();
        checkOutput("t3 back to idle", respValid, 0);
        checkOutput("t3 ready1 granted", req1Ready, 1);

        // Reset at SHIFT count 8 with requester 1 granted
        for (int k = 1; k <= 9; k++) begin
            stepCycle();
            req0Valid = k[0];
            #1;
            checkOutput("t4 no resp", respValid, 0);
            checkOutput("t4 ready0 ignored", req0Ready, 0);
        end
        reset = 1'b1;
        stepCycle();
        checkOutput("t4 resp_valid", respValid, 0);
        checkOutput("t4 resp_out", respOut, 0);
        checkOutput("t4 parity", respParity, 0);
        checkOutput("t4 id", respId, 0);
        checkOutput("t4 ready1", req1Ready, 0);
        reset = 1'b0;
        applyStimulus(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0000);
        checkOutput("t4 post ready0", req0Ready, 1);
        checkOutput("t4 post ready1", req1Ready, 0);
        applyStimulus(0, '0, '0, 0, '0, '0);
        stepCycle();
        checkOutput("t4 withdrawn valid", respValid, 0);
        checkOutput("t4 withdrawn ready0", req0Ready, 0);

        // Streaming from requester 1
        applyStimulus(0, '0, '0, 1, 16'h1234, 16'h1111);
        lastAccept  = -1;
        acceptCount = 0;
        respCount   = 0;
        for (int cyc = 0; cyc <= 56; cyc++) begin
            if (req1Ready) begin
                if (lastAccept >= 0) checkOutput("t5 accept gap", cyc - lastAccept, 18);
                lastAccept = cyc;
                acceptCount++;
            end
            if (respValid) begin
                respCount++;
                checkOutput("t5 out", respOut, 16'h0325);
                checkOutput("t5 parity", respParity, 1);
                checkOutput("t5 id", respId, 1);
            end
            stepCycle();
        end
        checkOutput("t5 accepts", acceptCount, 4);
        checkOutput("t5 responses", respCount, 3);
        applyStimulus(0, '0, '0, 0, '0, '0);

        // WIDTH=1 instance: a single shift cycle
        applyReset();
        w1Req0Valid = 1'b1;
        w1Req0A     = 1'b1;
        w1Req0B     = 1'b0;
        #1;
        checkOutput("w1 ready0", w1Req0Ready, 1);
        stepCycle();
        w1Req0Valid = 1'b0;
        lat = 1;
        while (!w1RespValid && lat < 10) begin
            stepCycle();
            lat++;
        end
        if (!w1RespValid) lat = -1;
        checkOutput("w1 latency", lat, 2);
        checkOutput("w1 out", w1RespOut, 1);
        checkOutput("w1 parity", w1RespParity, 1);
        stepCycle();

        // Equal operands
        applyReset();
        applyStimulus(1, 16'hA5A5, 16'hA5A5, 0, '0, '0);
        checkOutput("t6 ready0", req0Ready, 1);
        acceptAndWait(0, lat);
        checkOutput("t6 latency", lat, 17);
        checkOutput("t6 out", respOut, 16'h0000);
        checkOutput("t6 parity", respParity, 0);
        checkOutput("t6 id", respId, 0);
        stepCycle();

        $display("test done: total=%0d bad=%0d", numChecks, numFails);
        $finish;
    end

endmodule
